// File: rtl/led_mmio_port.sv
// Memory-mapped LED output port: DATA / CTRL / PERIOD / STATUS registers in a
// 16-byte window, a 32-bit blink timer, and a registered LED output word.
module led_mmio_port #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [31:0] BLINK_DIV = 32'd25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_be,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic [31:0] led_data
);

  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_CTRL   = 2'd1;
  localparam logic [1:0] SEL_PERIOD = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  // Merge the enabled bytes of a store into the current register value.
  function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // PERIOD = 0 behaves as 1 so the timer always makes progress.
  function automatic logic [31:0] eff_period(input logic [31:0] period);
    return (period == 32'd0) ? 32'd1 : period;
  endfunction

  logic [31:0] data_q;
  logic        blink_en_q;
  logic        invert_q;
  logic [31:0] period_q;
  logic [31:0] cnt_q;
  logic        phase_q;

  // ---- stage p0: address decode and access qualification ----
  logic        hit_p0;
  logic [1:0]  sel_p0;
  logic        wr_p0;
  logic        rd_p0;
  logic        period_wr_p0;
  logic        wrap_p0;
  logic [31:0] rd_val_p0;
  logic        unused_addr_lsb;

  assign hit_p0          = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign sel_p0          = bus_addr[3:2];
  assign wr_p0           = hit_p0 & bus_we;
  // A simultaneous write wins; the read half of the access is dropped.
  assign rd_p0           = hit_p0 & bus_re & ~bus_we;
  assign period_wr_p0    = wr_p0 & (sel_p0 == SEL_PERIOD);
  assign wrap_p0         = (cnt_q == eff_period(period_q) - 32'd1);
  assign unused_addr_lsb = ^bus_addr[1:0];

  // Read-data mux over the pre-edge register values.
  always_comb begin
    rd_val_p0 = 32'd0;
    case (sel_p0)
      SEL_DATA:   rd_val_p0 = data_q;
      SEL_CTRL:   rd_val_p0 = {30'd0, invert_q, blink_en_q};
      SEL_PERIOD: rd_val_p0 = period_q;
      SEL_STATUS: rd_val_p0 = {31'd0, phase_q};
      default:    rd_val_p0 = 32'd0;
    endcase
  end

  // ---- stage p1: registered state ----

  // Software-visible registers; STATUS writes are acknowledged but ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= 32'd0;
      blink_en_q <= 1'b0;
      invert_q   <= 1'b0;
      period_q   <= BLINK_DIV;
    end else if (wr_p0) begin
      case (sel_p0)
        SEL_DATA:   data_q <= be_merge(data_q, bus_wdata, bus_be);
        SEL_CTRL: begin
          if (bus_be[0]) begin
            blink_en_q <= bus_wdata[0];
            invert_q   <= bus_wdata[1];
          end
        end
        SEL_PERIOD: period_q <= be_merge(period_q, bus_wdata, bus_be);
        default: ;
      endcase
    end
  end

  // Blink timer: idle at cnt=0/phase=1 when disabled, so enabling always
  // starts a fresh half-period; a PERIOD write restarts the count only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 32'd0;
      phase_q <= 1'b1;
    end else if (!blink_en_q) begin
      cnt_q   <= 32'd0;
      phase_q <= 1'b1;
    end else if (period_wr_p0) begin
      cnt_q   <= 32'd0;
    end else if (wrap_p0) begin
      cnt_q   <= 32'd0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 32'd1;
    end
  end

  // LED word from pre-edge DATA, phase and CTRL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_data <= 32'd0;
    end else begin
      led_data <= ((phase_q | ~blink_en_q) ? data_q : 32'd0) ^ {32{invert_q}};
    end
  end

  // Bus response: one-cycle ready per hit, read data held until next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_ready <= 1'b0;
      bus_rdata <= 32'd0;
    end else begin
      bus_ready <= wr_p0 | rd_p0;
      if (rd_p0) bus_rdata <= rd_val_p0;
    end
  end

endmodule

// File: tb/tb_led_mmio_port.sv
// Bench for led_mmio_port: directed scenarios followed by random bus traffic,
// all checked each cycle against a behavioural register-level model.
module tb_led_mmio_port;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] DIV  = 32'd25_000_000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] bus_addr = 32'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [3:0]  bus_be = 4'd0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [31:0] led_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_data, m_period, m_led, m_rdata;
  logic        m_blink, m_inv, m_phase, m_ready;
  longint      m_cnt;

  led_mmio_port dut (
    .clk       (clk),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .led_data  (led_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 32'd0; m_blink = 1'b0; m_inv = 1'b0; m_period = DIV;
    m_cnt = 0; m_phase = 1'b1; m_led = 32'd0; m_rdata = 32'd0; m_ready = 1'b0;
  endtask

  // One clock edge of the model, using the inputs as they stood before it.
  task automatic model_edge();
    logic        hit, wr, rd;
    int          reg_idx;
    longint      eff;
    logic [31:0] regs [4];
    hit     = (bus_addr >> 4) == (BASE >> 4);
    reg_idx = int'((bus_addr % 16) / 4);
    wr      = hit && bus_we;
    rd      = hit && bus_re && !bus_we;
    regs[0] = m_data;
    regs[1] = 32'(m_blink) + 32'(m_inv) * 2;
    regs[2] = m_period;
    regs[3] = 32'(m_phase);
    eff     = (m_period == 0) ? 1 : longint'(m_period);

    m_led   = (m_phase || !m_blink) ? m_data : 32'd0;
    if (m_inv) m_led = ~m_led;
    m_ready = wr || rd;
    if (rd) m_rdata = regs[reg_idx];

    if (!m_blink) begin
      m_cnt = 0; m_phase = 1'b1;
    end else if (wr && reg_idx == 2) begin
      m_cnt = 0;
    end else if (m_cnt + 1 >= eff) begin
      m_cnt = 0; m_phase = !m_phase;
    end else begin
      m_cnt = m_cnt + 1;
    end

    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_be[b]) begin
          if (reg_idx == 0) m_data[8*b +: 8] = bus_wdata[8*b +: 8];
          if (reg_idx == 2) m_period[8*b +: 8] = bus_wdata[8*b +: 8];
        end
      end
      if (reg_idx == 1 && bus_be[0]) begin
        m_blink = bus_wdata[0];
        m_inv   = bus_wdata[1];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("led_data", led_data, m_led);
    check("bus_ready", {31'd0, bus_ready}, {31'd0, m_ready});
    check("bus_rdata", bus_rdata, m_rdata);
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic we, input logic re);
    bus_addr = a; bus_wdata = d; bus_be = be; bus_we = we; bus_re = re;
    step();
    bus_we = 1'b0; bus_re = 1'b0;
  endtask

  task automatic wr32(input logic [31:0] off, input logic [31:0] d);
    access(BASE + off, d, 4'hF, 1'b1, 1'b0);
  endtask

  task automatic rd32(input logic [31:0] off);
    access(BASE + off, 32'd0, 4'h0, 1'b0, 1'b1);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_led", led_data, 32'd0);
    check("rst_ready", {31'd0, bus_ready}, 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] v0, ra, rd_d;
    logic [3:0]  rbe;
    logic        rwe, rre;
    int          r;

    @(posedge clk); #1;
    do_reset();

    // Reset values visible through reads
    rd32(32'h8);
    check("rst_period", bus_rdata, 32'd25_000_000);
    rd32(32'hC);
    check("rst_status", bus_rdata, 32'd1);

    // Write DATA and read back
    wr32(32'h0, 32'h0000_000A);
    check("wr_ready", {31'd0, bus_ready}, 32'd1);
    step();
    check("wr_ready_drop", {31'd0, bus_ready}, 32'd0);
    check("wr_led", led_data, 32'h0000_000A);
    rd32(32'h0);
    check("rd_data", bus_rdata, 32'h0000_000A);

    // Byte enables and invert
    wr32(32'h0, 32'h0);
    access(BASE, 32'hFFFF_FFFF, 4'b0001, 1'b1, 1'b0);
    rd32(32'h0);
    check("be_data", bus_rdata, 32'h0000_00FF);
    wr32(32'h4, 32'd2);
    step();
    check("invert_led", led_data, 32'hFFFF_FF00);

    // Blink with PERIOD = 3
    wr32(32'h8, 32'd3);
    wr32(32'h0, 32'd5);
    wr32(32'h4, 32'd1);
    for (int i = 1; i <= 9; i++) begin
      step();
      check("blink3", led_data, (((i - 1) / 3) % 2 == 0) ? 32'd5 : 32'd0);
    end
    wr32(32'h4, 32'd0);
    step(); step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("blink_off", led_data, 32'd5);
    end

    // PERIOD = 0 toggles every cycle
    wr32(32'h8, 32'd0);
    wr32(32'h4, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      step();
      check("period0", led_data, (i % 2 == 1) ? 32'd5 : 32'd0);
    end

    // PERIOD rewritten mid-count: next toggle a full new period later
    wr32(32'h8, 32'd4);
    step(); step();
    wr32(32'h8, 32'd6);
    v0 = led_data;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("midperiod_hold", led_data, v0);
    end
    step();
    check("midperiod_toggle", led_data, v0 ^ 32'd5);
    wr32(32'h4, 32'd0);
    step();

    // Out-of-window access
    access(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
    check("miss_ready", {31'd0, bus_ready}, 32'd0);
    rd32(32'h0);
    check("miss_data", bus_rdata, 32'd5);

    // Simultaneous write and read
    rd32(32'hC);
    access(BASE, 32'h77, 4'hF, 1'b1, 1'b1);
    check("wr_rd_ready", {31'd0, bus_ready}, 32'd1);
    check("wr_rd_rdata", bus_rdata, 32'd1);
    step();
    check("wr_rd_single", {31'd0, bus_ready}, 32'd0);
    rd32(32'h0);
    check("wr_rd_data", bus_rdata, 32'h77);

    // STATUS is read-only
    wr32(32'hC, 32'hFFFF_FFFE);
    check("status_wr_ready", {31'd0, bus_ready}, 32'd1);
    rd32(32'hC);
    check("status_ro", bus_rdata, 32'd1);

    // Reset while a ready is pending
    rd32(32'h0);
    do_reset();
    rd32(32'h8);
    check("rst2_period", bus_rdata, 32'd25_000_000);

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      ra = $urandom;
      else if (r == 1) ra = BASE + 32'h10 + 32'($urandom_range(0, 15));
      else             ra = BASE + 32'($urandom_range(0, 15));
      rd_d = $urandom;
      if (ra[3:2] == 2'd2 && $urandom_range(0, 3) != 0) rd_d = 32'($urandom_range(0, 6));
      rbe = 4'($urandom_range(0, 15));
      rwe = ($urandom_range(0, 2) == 0);
      rre = ($urandom_range(0, 2) == 0);
      access(ra, rd_d, rbe, rwe, rre);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
